// File: rtl/minterm_extractor.sv
`default_nettype none
// ============================================================================
// Module   : minterm_extractor
// Purpose  : Scans a captured 2^N_VARS-bit truth table and streams the indices
//            of its minterms (table bit = 1) or maxterms (table bit = 0) in
//            ascending order over a valid/ready handshake. A one-cycle done
//            pulse is raised at the end, alongside the final term count.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            i_start      begin a scan (sampled only in IDLE)
//            i_mode       0 = minterms, 1 = maxterms (captured on start)
//            i_table      truth table, bit i = F(i) (captured on start)
//            o_busy       scan in progress
//            o_idx        current term index
//            o_idx_valid  o_idx holds a valid term
//            i_idx_ready  consumer accepts o_idx
//            o_last       o_idx is the final matching term
//            o_done       one-cycle completion pulse
//            o_count      number of terms emitted, held until next start
// Revision : 1.0 - initial release
// ============================================================================
module minterm_extractor #(
  parameter int N_VARS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [(1<<N_VARS)-1:0]   i_table,
  output logic                     o_busy,
  output logic [N_VARS-1:0]        o_idx,
  output logic                     o_idx_valid,
  input  logic                     i_idx_ready,
  output logic                     o_last,
  output logic                     o_done,
  output logic [N_VARS:0]          o_count
);

  localparam int TW = 1 << N_VARS;
  localparam logic [N_VARS-1:0] c_IMAX = {N_VARS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [TW-1:0]       r_table;
  logic                r_mode;
  logic [N_VARS-1:0]   r_i;
  logic [N_VARS-1:0]   r_idx;
  logic                r_idx_valid;
  logic                r_last;
  logic                r_done;
  logic                r_busy;
  logic [N_VARS:0]     r_count;

  logic [TW-1:0]       w_match_vec;
  logic [TW-1:0]       w_upper;
  logic                w_match;
  logic                w_none_above;
  logic                w_hs;

  // Maxterm mode simply inverts the table so both modes search for ones.
  assign w_match_vec  = r_table ^ {TW{r_mode}};
  // Bring bit i down to position 0; everything above it tells us whether
  // this is the final matching term.
  assign w_upper      = w_match_vec >> r_i;
  assign w_match      = w_upper[0];
  assign w_none_above = (w_upper[TW-1:1] == '0);
  assign w_hs         = r_idx_valid & i_idx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_table     <= '0;
      r_mode      <= 1'b0;
      r_i         <= '0;
      r_idx       <= '0;
      r_idx_valid <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_table <= i_table;
            r_mode  <= i_mode;
            r_i     <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_idx       <= r_i;
            r_idx_valid <= 1'b1;
            r_last      <= w_none_above;
            r_state     <= S_EMIT;
          end else if (r_i != c_IMAX) begin
            r_i <= r_i + 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            r_count     <= r_count + 1'b1;
            r_idx_valid <= 1'b0;
            r_last      <= 1'b0;
            // Stop at the top index so r_i never wraps back to 0.
            if (r_i == c_IMAX) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_i     <= r_i + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          // start is deliberately not sampled here.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_idx       = r_idx;
  assign o_idx_valid = r_idx_valid;
  assign o_last      = r_last;
  assign o_done      = r_done;
  assign o_count     = r_count;

endmodule
`default_nettype wire

// File: doc/minterm_extractor.md
# minterm_extractor

Sequential truth-table analyser that converts a captured 2^N_VARS-bit function table into the ordered list of its minterm indices (sum-of-products form) or maxterm indices (product-of-sums form). Each matching index is streamed out over a valid/ready handshake, and the block reports the term count on completion. It sits downstream of the combinational logic-function blocks and turns a function back into its canonical term list for checking and display.

## Interface
- N_VARS, 4, number of function inputs; table width is 2^N_VARS and index width is N_VARS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a scan; sampled only in IDLE.
- mode  in  1  term type: 0 = minterms (table bit = 1), 1 = maxterms (table bit = 0); captured on start.
- table_in  in  2^N_VARS  function truth table; bit i = F(i), where i = {a,b,c,d} with a as MSB; captured on start.
- busy  out  1  high from the cycle after start is accepted until done.
- idx  out  N_VARS  current term index.
- idx_valid  out  1  idx holds a valid term.
- idx_ready  in  1  consumer accepts idx.
- last  out  1  qualifies idx_valid; high when idx is the final matching term.
- done  out  1  one-cycle completion pulse.
- count  out  N_VARS+1  number of terms emitted; final value is valid with done and held until the next accepted start.

## Operation
- States: IDLE, SCAN, EMIT, DONE.
- IDLE: when start=1, capture table_in and mode, clear the index counter i and count, then go to SCAN. busy=1 from the next cycle.
- SCAN: examine bit i each cycle, where match = table[i] XOR mode.
  - match=1: load idx<=i, set idx_valid<=1, set last<=(no matching bit above i), go to EMIT.
  - match=0 and i<max: i<=i+1.
  - match=0 and i=max: go to DONE.
- EMIT: hold idx, idx_valid and last stable while idx_ready=0.
  - On handshake (idx_valid & idx_ready): count<=count+1, idx_valid<=0, last<=0.
  - After the handshake, go to DONE if i=max; otherwise set i<=i+1 and go to SCAN.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- start is ignored whenever the state is not IDLE. A start on the done cycle is also ignored.
- Indices are emitted strictly ascending. Each index is emitted at most once.
- count width N_VARS+1 holds 2^N_VARS without wrap. The counter i never wraps past max.
- Empty result (no matching bit): no idx_valid, last never asserts, done with count=0.
- Full result: all 2^N_VARS indices are emitted and count=2^N_VARS.

## Timing
- Reset values: busy=0, idx=0, idx_valid=0, last=0, done=0, count=0, state=IDLE.
- rst_n low mid-scan clears all state and outputs immediately. No done pulse is produced and the scan is abandoned.
- Start accepted at edge E0. Index i is first examined at edge E0+1.
- A non-matching index costs 1 cycle. A matching index costs 1 cycle plus at least 1 handshake cycle.
- idx_valid rises the cycle after its index is examined. With idx_ready held high, the next index is examined the cycle after the handshake.
- No matches: done is high in the cycle following E0+2^N_VARS.
- All matches with idx_ready=1: done is high in the cycle following E0+2·2^N_VARS.
- done coincides with the final count value. count updates on the handshake edge.
- idx_ready is ignored while idx_valid=0.

## Test plan
- Table 0xD153, mode=0, idx_ready=1 -> idx stream 0,1,4,6,8,12,14,15; last only on 15; count=8 at done.
- Table 0xD153, mode=1 -> idx stream 2,3,5,7,9,10,11,13; last on 13; count=8.
- Table 0x0000, mode=0 -> no idx_valid; done exactly 16 cycles after the start edge; count=0. Then table 0x0000, mode=1 -> 16 indices 0..15; count=16 with no wrap.
- Table 0x8001, mode=0, idx_ready held low for 5 cycles on each term -> idx stays 0 (then 15) stable throughout; last asserted only with 15; count=2.
- start pulsed repeatedly while busy and on the done cycle -> ignored; scan results are unchanged.
- rst_n asserted while idx_valid=1 mid-stream -> all outputs 0 immediately and no done pulse. A new start after release scans from index 0.
